// File: rtl/ysyx_25040111_pkg.sv
// rtl/ysyx_25040111_pkg.sv - shared constants for the write-back unit
package ysyx_25040111_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] WBU_IDLE     = 2'd0;
    localparam logic [1:0] WBU_WAIT_MEM = 2'd1;
    localparam logic [1:0] WBU_WRITE    = 2'd2;

endpackage

// File: rtl/ysyx_25040111_wbu_if.sv
// rtl/ysyx_25040111_wbu_if.sv - retire, load-response, regfile and commit signals of the write-back unit
interface ysyx_25040111_wbu_if #(
    parameter int XLEN  = 32,
    parameter int RBITS = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [RBITS-1:0] in_rd;
    logic             in_rd_wen;
    logic             in_is_load;
    logic [2:0]       in_funct3;
    logic [1:0]       in_addr_lo;
    logic [XLEN-1:0]  in_result;
    logic [XLEN-1:0]  in_pc;
    logic             mem_rvalid;
    logic             mem_rready;
    logic [XLEN-1:0]  mem_rdata;
    logic             rf_wen;
    logic [RBITS-1:0] rf_waddr;
    logic [XLEN-1:0]  rf_wdata;
    logic             commit_valid;
    logic [XLEN-1:0]  commit_pc;
    logic             pend_valid;
    logic [RBITS-1:0] pend_rd;

    modport master (
        output in_valid, in_rd, in_rd_wen, in_is_load, in_funct3, in_addr_lo,
               in_result, in_pc, mem_rvalid, mem_rdata,
        input  in_ready, mem_rready, rf_wen, rf_waddr, rf_wdata,
               commit_valid, commit_pc, pend_valid, pend_rd
    );

    modport slave (
        input  in_valid, in_rd, in_rd_wen, in_is_load, in_funct3, in_addr_lo,
               in_result, in_pc, mem_rvalid, mem_rdata,
        output in_ready, mem_rready, rf_wen, rf_waddr, rf_wdata,
               commit_valid, commit_pc, pend_valid, pend_rd
    );
endinterface

// File: rtl/ysyx_25040111_wbu_ldext.sv
// rtl/ysyx_25040111_wbu_ldext.sv - combinational lane select and sign/zero extension of load data
module ysyx_25040111_wbu_ldext
    import ysyx_25040111_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Halfword lane uses addr_lo[1] only; a misaligned bit 0 is silently dropped.
    assign byte_v = rdata[{addr_lo, 3'b000} +: 8];
    assign half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        data = rdata;
        case (funct3)
            F3_LB:   data = {{(XLEN-8){byte_v[7]}}, byte_v};
            F3_LH:   data = {{(XLEN-16){half_v[15]}}, half_v};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_v};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, half_v};
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/ysyx_25040111_wbu.sv
// rtl/ysyx_25040111_wbu.sv - write-back unit: retire handshake, load wait, regfile write and commit strobe
module ysyx_25040111_wbu
    import ysyx_25040111_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RBITS = 4
) (
    input logic                 clock,
    input logic                 reset,
    ysyx_25040111_wbu_if.slave  bus
);
    logic [1:0]       state;
    logic [RBITS-1:0] rd_q;
    logic             rd_wen_q;
    logic             is_load_q;
    logic [2:0]       funct3_q;
    logic [1:0]       addr_lo_q;
    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  data_q;
    logic [XLEN-1:0]  ext_data;
    logic             accept;
    logic             writes_reg;

    ysyx_25040111_wbu_ldext #(.XLEN(XLEN)) u_ldext (
        .funct3  (funct3_q),
        .addr_lo (addr_lo_q),
        .rdata   (bus.mem_rdata),
        .data    (ext_data)
    );

    // Ready signals depend only on state and reset so no input-to-output path exists.
    assign bus.in_ready   = (state == WBU_IDLE || state == WBU_WRITE) && !reset;
    assign bus.mem_rready = (state == WBU_WAIT_MEM) && !reset;
    assign accept         = bus.in_valid && bus.in_ready;
    assign writes_reg     = rd_wen_q && (rd_q != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= WBU_IDLE;
            rd_q      <= '0;
            rd_wen_q  <= 1'b0;
            is_load_q <= 1'b0;
            funct3_q  <= '0;
            addr_lo_q <= '0;
            pc_q      <= '0;
            data_q    <= '0;
        end else begin
            case (state)
                WBU_IDLE, WBU_WRITE: begin
                    if (accept) begin
                        rd_q      <= bus.in_rd;
                        rd_wen_q  <= bus.in_rd_wen;
                        is_load_q <= bus.in_is_load;
                        funct3_q  <= bus.in_funct3;
                        addr_lo_q <= bus.in_addr_lo;
                        pc_q      <= bus.in_pc;
                        if (bus.in_is_load) begin
                            state <= WBU_WAIT_MEM;
                        end else begin
                            data_q <= bus.in_result;
                            state  <= WBU_WRITE;
                        end
                    end else begin
                        state <= WBU_IDLE;
                    end
                end
                WBU_WAIT_MEM: begin
                    if (bus.mem_rvalid) begin
                        data_q <= ext_data;
                        state  <= WBU_WRITE;
                    end
                end
                default: state <= WBU_IDLE;
            endcase
        end
    end

    // In WRITE the regfile forwards the data, so pending still reports the rd there.
    assign bus.rf_wen       = (state == WBU_WRITE) && writes_reg;
    assign bus.rf_waddr     = rd_q;
    assign bus.rf_wdata     = data_q;
    assign bus.commit_valid = (state == WBU_WRITE);
    assign bus.commit_pc    = pc_q;
    assign bus.pend_valid   = (state == WBU_WAIT_MEM || state == WBU_WRITE) && writes_reg;
    assign bus.pend_rd      = rd_q;

    logic unused_ok;
    assign unused_ok = is_load_q;
endmodule

// File: tb/tb_ysyx_25040111_wbu.sv
// tb/tb_ysyx_25040111_wbu.sv - scoreboard bench for the write-back unit
module tb_ysyx_25040111_wbu;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    typedef struct {
        logic        wen;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];

    ysyx_25040111_wbu_if #(.XLEN(32), .RBITS(4)) bus ();

    ysyx_25040111_wbu #(.XLEN(32), .RBITS(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Monitor: every commit strobe pops one expected retirement.
    always @(negedge clock) begin
        if (!reset && bus.rf_wen && !bus.commit_valid) begin
            checks++;
            errors++;
            $display("FAIL wen_without_commit actual=1 required=0");
        end
        if (!reset && bus.commit_valid) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_commit pc actual=0x%08h required=none", bus.commit_pc);
            end else begin
                e = exp_q.pop_front();
                if (bus.rf_wen !== e.wen || bus.commit_pc !== e.pc || bus.rf_wdata !== e.data
                    || (e.wen && bus.rf_waddr !== e.addr)) begin
                    errors++;
                    $display("FAIL commit wen/addr/data/pc actual=%0b/%0d/0x%08h/0x%08h required=%0b/%0d/0x%08h/0x%08h",
                             bus.rf_wen, bus.rf_waddr, bus.rf_wdata, bus.commit_pc,
                             e.wen, e.addr, e.data, e.pc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [3:0] rd, input logic wen, input logic ld, input logic [2:0] f3,
                         input logic [1:0] alo, input logic [31:0] res, input logic [31:0] pc);
        int n;
        bus.in_valid   = 1'b1;
        bus.in_rd      = rd;
        bus.in_rd_wen  = wen;
        bus.in_is_load = ld;
        bus.in_funct3  = f3;
        bus.in_addr_lo = alo;
        bus.in_result  = res;
        bus.in_pc      = pc;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout actual=0 required=1");
        end
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic alu(input logic [3:0] rd, input logic [31:0] res, input logic [31:0] pc);
        exp_q.push_back('{wen: (rd != 0), addr: rd, data: res, pc: pc});
        drive(rd, 1'b1, 1'b0, 3'b010, 2'd0, res, pc);
        check("alu_commit_next_cycle", 32'(bus.commit_valid), 32'd1);
        check("alu_in_ready_in_write", 32'(bus.in_ready), 32'd1);
        check("alu_pend_valid", 32'(bus.pend_valid), 32'(rd != 0));
    endtask

    task automatic load(input logic [3:0] rd, input logic [2:0] f3, input logic [1:0] alo,
                        input logic [31:0] rdata, input int wait_n, input logic [31:0] exp_data,
                        input logic [31:0] pc);
        exp_q.push_back('{wen: (rd != 0), addr: rd, data: exp_data, pc: pc});
        drive(rd, 1'b1, 1'b1, f3, alo, 32'hDEAD_BEEF, pc);
        for (int i = 0; i < wait_n; i++) begin
            check("wait_pend_valid", 32'(bus.pend_valid), 32'd1);
            check("wait_pend_rd", 32'(bus.pend_rd), 32'(rd));
            check("wait_mem_rready", 32'(bus.mem_rready), 32'd1);
            check("wait_no_commit", 32'(bus.commit_valid), 32'd0);
            step();
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata;
        step();
        bus.mem_rvalid = 1'b0;
        check("load_commit", 32'(bus.commit_valid), 32'd1);
        check("load_wdata", bus.rf_wdata, exp_data);
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_rd      = '0;
        bus.in_rd_wen  = 1'b0;
        bus.in_is_load = 1'b0;
        bus.in_funct3  = '0;
        bus.in_addr_lo = '0;
        bus.in_result  = '0;
        bus.in_pc      = '0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        repeat (3) step();
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_mem_rready", 32'(bus.mem_rready), 32'd0);
        check("rst_rf_wen", 32'(bus.rf_wen), 32'd0);
        check("rst_rf_waddr", 32'(bus.rf_waddr), 32'd0);
        check("rst_rf_wdata", bus.rf_wdata, 32'd0);
        check("rst_commit", 32'(bus.commit_valid), 32'd0);
        check("rst_commit_pc", bus.commit_pc, 32'd0);
        check("rst_pend", 32'(bus.pend_valid), 32'd0);
        reset = 1'b0;
        step();
        check("in_ready_after_reset", 32'(bus.in_ready), 32'd1);

        alu(4'd5, 32'h1234_5678, 32'h8000_0000);
        step();

        load(4'd3, 3'b000, 2'd2, 32'h0080_0000, 3, 32'hFFFF_FF80, 32'h8000_0004);
        load(4'd3, 3'b100, 2'd2, 32'h0080_0000, 3, 32'h0000_0080, 32'h8000_0008);
        load(4'd4, 3'b001, 2'd3, 32'h8001_7FFF, 1, 32'hFFFF_8001, 32'h8000_000C);
        load(4'd4, 3'b101, 2'd3, 32'h8001_7FFF, 1, 32'h0000_8001, 32'h8000_0010);
        load(4'd6, 3'b010, 2'd3, 32'h8001_7FFF, 0, 32'h8001_7FFF, 32'h8000_0014);
        load(4'd6, 3'b001, 2'd0, 32'h1234_8765, 0, 32'hFFFF_8765, 32'h8000_0018);

        alu(4'd1, 32'h0000_0011, 32'h8000_0020);
        alu(4'd2, 32'h0000_0022, 32'h8000_0024);
        alu(4'd0, 32'h0000_0033, 32'h8000_0028);
        step();
        check("idle_after_burst", 32'(bus.commit_valid), 32'd0);

        drive(4'd7, 1'b1, 1'b1, 3'b010, 2'd0, 32'h0, 32'h8000_0030);
        check("pre_reset_pend", 32'(bus.pend_valid), 32'd1);
        reset          = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hCAFE_F00D;
        step();
        check("midrst_commit", 32'(bus.commit_valid), 32'd0);
        check("midrst_rf_wen", 32'(bus.rf_wen), 32'd0);
        check("midrst_pend", 32'(bus.pend_valid), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        check("midrst_wdata", bus.rf_wdata, 32'd0);
        reset          = 1'b0;
        bus.mem_rvalid = 1'b0;
        step();
        check("in_ready_after_midrst", 32'(bus.in_ready), 32'd1);
        check("midrst_no_late_commit", 32'(bus.commit_valid), 32'd0);

        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1122_3344;
        step();
        check("idle_mem_rready", 32'(bus.mem_rready), 32'd0);
        check("idle_no_write", 32'(bus.rf_wen), 32'd0);
        step();
        check("idle_mem_rready2", 32'(bus.mem_rready), 32'd0);
        exp_q.push_back('{wen: 1'b1, addr: 4'd9, data: 32'h1122_3344, pc: 32'h8000_0040});
        drive(4'd9, 1'b1, 1'b1, 3'b010, 2'd1, 32'h0, 32'h8000_0040);
        check("held_rdata_consumed_rready", 32'(bus.mem_rready), 32'd1);
        step();
        bus.mem_rvalid = 1'b0;
        check("held_rdata_commit", 32'(bus.commit_valid), 32'd1);
        step();

        repeat (2) step();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
